serial_operand_sequencer: RTL and testbench
===========================================

// Module: serial_operand_sequencer
// PURPOSE
//  Upstream feeder for the bit-serial alu. Accepts two WIDTH-bit operands and a 3-bit op
//  through a valid/ready handshake. Clears the alu carry/result register, then presents
//  operand bits LSB-first, one bit per clock, on alu_ina/alu_inb.
//  Collects alu_out each cycle into a result word and returns it through a valid/ready handshake.
// PARAMETERS
//  WIDTH  16               operand/result width in bits (>=2)
//  CNT_W  $clog2(WIDTH)    width of the bit-index counter
// PORTS
//  clk         in   1      single clock; all state updates on posedge clk
//  rst         in   1      synchronous, active-high reset
//  in_valid    in   1      operand request valid
//  in_ready    out  1      sequencer can accept a request
//  in_a        in   WIDTH  operand A
//  in_b        in   WIDTH  operand B
//  in_op       in   3      op code (seq_pkg::op_e)
//  alu_ina     out  1      current bit of A to alu
//  alu_inb     out  1      current bit of B to alu
//  alu_op      out  3      op held stable for the whole operation
//  alu_clr     out  1      one-cycle clear of the alu carry register
//  alu_en      out  1      alu step strobe; alu register advances on edges where alu_en=1
//  alu_out     in   1      alu combinational result bit for current inputs and carry
//  alu_regout  in   1      alu registered carry
//  res_valid   out  1      result available
//  res_ready   in   1      consumer accepts result
//  res_data    out  WIDTH  result word
//  res_carry   out  1      final carry (SEQ_CARRY_FLAG_EN only)
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, in_ready=1; every other output=0, including res_data and res_carry.
//  IDLE:
//   - in_ready=1.
//   - On in_valid&in_ready: latch in_a, in_b and in_op into shift registers; go to CLEAR.
//  CLEAR (1 cycle):
//   - alu_clr=1, alu_en=0, in_ready=0, bit counter=0; go to SHIFT.
//  SHIFT (WIDTH cycles):
//   - alu_en=1; alu_ina/alu_inb = bit[cnt] of the latched operands.
//   - At each edge: alu_out is shifted into res_data MSB-side (shift right), and cnt increments.
//   - After the bit at cnt==WIDTH-1: go to CARRY when the macro is defined, else to DONE.
//  DONE:
//   - res_valid=1; res_data and res_carry held stable while res_ready=0.
//   - On res_ready: res_valid=0, go to IDLE.
//   - in_ready=0 here, so a new request is not accepted in the same cycle.
//  Latency (handshake edge=T):
//   - alu_clr at T+1; bit i on T+2+i; res_valid from T+WIDTH+2 (+1 with macro).
//   - Throughput: one operation per WIDTH+3 cycles with res_ready tied high.
//  Output rules:
//   - alu_op is driven only outside IDLE; it is 0 in IDLE.
//   - alu_ina/alu_inb are 0 whenever alu_en=0.
//   - Reserved op codes (110,111) are passed through unchanged; the result is whatever the alu returns.
//  Boundary conditions:
//   - rst mid-operation: next cycle IDLE, all outputs at reset values, the partial result is discarded.
//   - rst has priority over all handshakes.
//   - in_valid while busy is ignored (in_ready=0). The requester must hold its data until it is accepted.
//   - Counter wrap: cnt is never allowed to wrap. The exit from SHIFT is decoded at WIDTH-1.
// CONFIGURATION
//  SEQ_CARRY_FLAG_EN defined:
//   - A CARRY state of 1 cycle is inserted after SHIFT (alu_en=0), in which alu_regout is captured into res_carry.
//  SEQ_CARRY_FLAG_EN undefined:
//   - No CARRY state, res_carry is tied 0, latency is 1 cycle shorter.
// STRUCTURE
//  seq_pkg:
//   - state_e {IDLE, CLEAR, SHIFT, CARRY, DONE}
//   - op_e {OP_ADD=3'b000, OP_AND=001, OP_OR=010, OP_XOR=011, OP_NOT=100 (uses A only), OP_NAND=101}
//   - SEQ_OP_W=3
//  One sub-module, seq_bit_counter:
//   - CNT_W-bit synchronous counter with clear, enable and a last flag (cnt==WIDTH-1).
// TESTING (bench instantiates the alu model)
//  1. OP_ADD A=16'h1234 B=16'h0FFF -> res_data=16'h2233; res_carry=0; res_valid at T+18 (T+19 with macro).
//  2. OP_ADD A=16'hFFFF B=16'h0001 -> res_data=16'h0000; res_carry=1 with macro, 0 without.
//  3. OP_XOR A=16'hA5A5 B=16'hFFFF -> 16'h5A5A. OP_NAND same operands -> 16'h5A5A. OP_AND -> 16'hA5A5.
//  4. res_ready=0 for 5 cycles in DONE -> res_valid=1, res_data stable, in_ready=0; release -> IDLE next cycle.
//  5. rst at bit 7 of SHIFT -> next cycle alu_en=0, res_valid=0, res_data=0, in_ready=1.
//     A following OP_OR 16'h00F0|16'h0F00 -> 16'h0FF0.
//  6. Back-to-back requests, in_valid held high, res_ready tied 1 -> exactly one accept per WIDTH+3 cycles
//     (WIDTH+4 with macro); results in order.

Source files
------------

// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared types and constants for the serial operand sequencer that feeds the
// bit-serial alu.
//   state_e  : sequencer FSM states
//   op_e     : alu op codes (110 and 111 are reserved and pass through as-is)
//   SEQ_OP_W : width of the op code field
// ---------------------------------------------------------------------------
package seq_pkg;

    localparam int SEQ_OP_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        CARRY,
        DONE
    } state_e;

    typedef enum logic [SEQ_OP_W-1:0] {
        OP_ADD  = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_XOR  = 3'b011,
        OP_NOT  = 3'b100,
        OP_NAND = 3'b101
    } op_e;

endpackage

// File: rtl/seq_bit_counter.sv
// ---------------------------------------------------------------------------
// seq_bit_counter
// Bit-index counter for the serial sequencer. Clears to 0, advances by one on
// each enabled clock, and raises 'last' while the index equals WIDTH-1. The
// index saturates at WIDTH-1 instead of wrapping.
// Ports:
//   clk   in   1  clock
//   rst   in   1  synchronous active-high reset
//   clr   in   1  return the index to 0 (wins over en)
//   en    in   1  advance the index
//   last  out  1  index is WIDTH-1
// ---------------------------------------------------------------------------
module seq_bit_counter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating at the last index keeps the counter from wrapping; the FSM
    // leaves SHIFT on that same cycle, so the held value is never used.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST_IDX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == LAST_IDX);

endmodule

// File: rtl/serial_operand_sequencer.sv
// ---------------------------------------------------------------------------
// serial_operand_sequencer
// Upstream feeder for the bit-serial alu. Takes two WIDTH-bit operands and an
// op code through a valid/ready handshake, clears the alu carry register,
// streams the operand bits LSB-first (one per clock), gathers alu_out into a
// result word and returns it through a second valid/ready handshake.
//
// Build option: define SEQ_CARRY_FLAG_EN to add a one-cycle CARRY state after
// the last bit in which the alu registered carry is captured into res_carry.
// Without it res_carry is tied to 0 and each operation is one cycle shorter.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             operand request handshake
//   in_a, in_b, in_op             operands and op code
//   alu_ina, alu_inb              current operand bits (0 when alu_en=0)
//   alu_op                        op held for the whole operation, 0 in IDLE
//   alu_clr                       one-cycle clear of the alu carry register
//   alu_en                        alu step strobe
//   alu_out, alu_regout           alu result bit and registered carry
//   res_valid/res_ready           result handshake
//   res_data, res_carry           result word and final carry
// ---------------------------------------------------------------------------
module serial_operand_sequencer
    import seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic [SEQ_OP_W-1:0] in_op,
    output logic                alu_ina,
    output logic                alu_inb,
    output logic [SEQ_OP_W-1:0] alu_op,
    output logic                alu_clr,
    output logic                alu_en,
    input  logic                alu_out,
    input  logic                alu_regout,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [WIDTH-1:0]    res_data,
    output logic                res_carry
);

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      a_q, a_d;
    logic [WIDTH-1:0]      b_q, b_d;
    logic [SEQ_OP_W-1:0]   op_q, op_d;
    logic [WIDTH-1:0]      res_q, res_d;
    logic                  cnt_clr;
    logic                  cnt_en;
    logic                  cnt_last;

    seq_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .last (cnt_last)
    );

    // Next-state and output decode. The operand registers shift right while
    // streaming so bit 0 always holds the bit at the current index; the
    // result fills from the MSB side so the first bit lands in bit 0.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        res_d     = res_q;
        in_ready  = 1'b0;
        alu_ina   = 1'b0;
        alu_inb   = 1'b0;
        alu_op    = '0;
        alu_clr   = 1'b0;
        alu_en    = 1'b0;
        res_valid = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    op_d    = in_op;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                alu_op  = op_q;
                alu_clr = 1'b1;
                cnt_clr = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                alu_op  = op_q;
                alu_en  = 1'b1;
                cnt_en  = 1'b1;
                alu_ina = a_q[0];
                alu_inb = b_q[0];
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                res_d   = {alu_out, res_q[WIDTH-1:1]};
                if (cnt_last) begin
`ifdef SEQ_CARRY_FLAG_EN
                    state_d = CARRY;
`else
                    state_d = DONE;
`endif
                end
            end
            CARRY: begin
                alu_op  = op_q;
                state_d = DONE;
            end
            DONE: begin
                alu_op    = op_q;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    assign res_data = res_q;

`ifdef SEQ_CARRY_FLAG_EN
    logic carry_q, carry_d;

    // The alu holds its carry while alu_en=0, so the CARRY state sees the
    // carry left behind by the final bit.
    always_comb begin
        carry_d = carry_q;
        if (state_q == CARRY) begin
            carry_d = alu_regout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign res_carry = carry_q;
`else
    logic unused_alu_regout;
    assign unused_alu_regout = alu_regout;
    assign res_carry         = 1'b0;
`endif

endmodule

// File: tb/tb_serial_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_serial_operand_sequencer
// Drives the sequencer together with a small bit-serial alu model and checks
// results, latency, handshakes, stalls, mid-operation reset and back-to-back
// throughput against an arithmetic reference of each op.
// Honours SEQ_CARRY_FLAG_EN for the expected carry flag and latency.
// ---------------------------------------------------------------------------
module tb_serial_operand_sequencer;
    import seq_pkg::*;

    localparam int WIDTH = 16;
`ifdef SEQ_CARRY_FLAG_EN
    localparam int CARRY_EXTRA = 1;
`else
    localparam int CARRY_EXTRA = 0;
`endif
    localparam int LATENCY = WIDTH + 2 + CARRY_EXTRA;
    localparam int PERIOD  = WIDTH + 3 + CARRY_EXTRA;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             alu_ina;
    logic             alu_inb;
    logic [2:0]       alu_op;
    logic             alu_clr;
    logic             alu_en;
    logic             alu_out;
    logic             alu_regout;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;

    int checks = 0;
    int errors = 0;

    serial_operand_sequencer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .alu_ina    (alu_ina),
        .alu_inb    (alu_inb),
        .alu_op     (alu_op),
        .alu_clr    (alu_clr),
        .alu_en     (alu_en),
        .alu_out    (alu_out),
        .alu_regout (alu_regout),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_carry  (res_carry)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-serial alu model: a carry register stepped by alu_en and cleared by
    // alu_clr, with a combinational result bit. Reserved ops return 0.
    logic alu_carry_q;

    always_ff @(posedge clk) begin
        if (rst || alu_clr) begin
            alu_carry_q <= 1'b0;
        end else if (alu_en) begin
            if (alu_op == OP_ADD) begin
                alu_carry_q <= (alu_ina & alu_inb) | (alu_ina & alu_carry_q) | (alu_inb & alu_carry_q);
            end else begin
                alu_carry_q <= 1'b0;
            end
        end
    end

    always_comb begin
        alu_out = 1'b0;
        case (alu_op)
            OP_ADD:  alu_out = alu_ina ^ alu_inb ^ alu_carry_q;
            OP_AND:  alu_out = alu_ina & alu_inb;
            OP_OR:   alu_out = alu_ina | alu_inb;
            OP_XOR:  alu_out = alu_ina ^ alu_inb;
            OP_NOT:  alu_out = ~alu_ina;
            OP_NAND: alu_out = ~(alu_ina & alu_inb);
            default: alu_out = 1'b0;
        endcase
    end

    assign alu_regout = alu_carry_q;

    // Word-level reference: {carry, result} of one whole operation.
    function automatic logic [WIDTH:0] refModel(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_NOT:  return {1'b0, ~a};
            OP_NAND: return {1'b0, ~(a & b)};
            default: return '0;
        endcase
    endfunction

    function automatic logic expCarry(input logic [WIDTH:0] r);
`ifdef SEQ_CARRY_FLAG_EN
        return r[WIDTH];
`else
        return 1'b0 & r[WIDTH];
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One complete transaction starting at a negedge in IDLE. The result is
    // held for 'stall' extra cycles with res_ready low before release.
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input int stall);
        logic [WIDTH:0]   expv;
        logic [WIDTH-1:0] seen_a;
        logic [WIDTH-1:0] seen_b;
        int               n;
        bit               got;

        expv   = refModel(op, a, b);
        seen_a = '0;
        seen_b = '0;
        n      = 0;
        got    = 1'b0;

        res_ready = (stall == 0);
        checkOutput({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        in_op    = 3'($urandom);

        checkOutput({tag, " clear alu_clr"}, 32'(alu_clr), 32'd1);
        checkOutput({tag, " clear alu_en"}, 32'(alu_en), 32'd0);
        checkOutput({tag, " busy alu_op"}, 32'(alu_op), 32'(op));
        checkOutput({tag, " busy in_ready"}, 32'(in_ready), 32'd0);

        while (!got && n < LATENCY + 20) begin
            if (res_valid) begin
                got = 1'b1;
            end else begin
                if (alu_en) begin
                    seen_a = {alu_ina, seen_a[WIDTH-1:1]};
                    seen_b = {alu_inb, seen_b[WIDTH-1:1]};
                end
                @(posedge clk);
                n++;
                @(negedge clk);
            end
        end

        checkOutput({tag, " latency"}, got ? 32'(n + 1) : 32'd0, 32'(LATENCY));
        checkOutput({tag, " streamed A"}, 32'(seen_a), 32'(a));
        checkOutput({tag, " streamed B"}, 32'(seen_b), 32'(b));
        checkOutput({tag, " res_data"}, 32'(res_data), 32'(expv[WIDTH-1:0]));
        checkOutput({tag, " res_carry"}, 32'(res_carry), 32'(expCarry(expv)));

        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_a     = WIDTH'($urandom);
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, " stall res_valid"}, 32'(res_valid), 32'd1);
            checkOutput({tag, " stall res_data"}, 32'(res_data), 32'(expv[WIDTH-1:0]));
            checkOutput({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput({tag, " release res_valid"}, 32'(res_valid), 32'd0);
        checkOutput({tag, " release in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, " release alu_op"}, 32'(alu_op), 32'd0);
    endtask

    // Main directed sequence followed by randomized transactions.
    initial begin
        logic [WIDTH:0]   expq[$];
        logic [WIDTH:0]   expv;
        logic [WIDTH-1:0] ra[5];
        logic [WIDTH-1:0] rb[5];
        logic [2:0]       rop[5];
        int               idx;
        int               cyc;
        int               last_accept;
        int               results;
        bit               accept;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        res_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset res_valid", 32'(res_valid), 32'd0);
        checkOutput("reset res_data", 32'(res_data), 32'd0);
        checkOutput("reset res_carry", 32'(res_carry), 32'd0);
        checkOutput("reset alu_en", 32'(alu_en), 32'd0);
        checkOutput("reset alu_clr", 32'(alu_clr), 32'd0);
        checkOutput("reset alu_op", 32'(alu_op), 32'd0);
        checkOutput("reset alu_ina", 32'(alu_ina), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        $display("[TB] directed operations");
        applyStimulus("add1", OP_ADD, 16'h1234, 16'h0FFF, 0);
        checkOutput("add1 ref", 32'(refModel(OP_ADD, 16'h1234, 16'h0FFF)), 32'h2233);
        applyStimulus("add2", OP_ADD, 16'hFFFF, 16'h0001, 0);
        applyStimulus("xor", OP_XOR, 16'hA5A5, 16'hFFFF, 0);
        applyStimulus("nand", OP_NAND, 16'hA5A5, 16'hFFFF, 0);
        applyStimulus("and", OP_AND, 16'hA5A5, 16'hFFFF, 0);
        applyStimulus("not", OP_NOT, 16'h00FF, 16'h1234, 0);
        applyStimulus("stall5", OP_XOR, 16'h1357, 16'h2468, 5);

        $display("[TB] reset during shift");
        in_valid = 1'b1;
        in_a     = 16'hBEEF;
        in_b     = 16'h1111;
        in_op    = OP_ADD;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("midrst shifting", 32'(alu_en), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst alu_en", 32'(alu_en), 32'd0);
        checkOutput("midrst res_valid", 32'(res_valid), 32'd0);
        checkOutput("midrst res_data", 32'(res_data), 32'd0);
        checkOutput("midrst in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst alu_op", 32'(alu_op), 32'd0);
        applyStimulus("or_after_rst", OP_OR, 16'h00F0, 16'h0F00, 0);

        $display("[TB] back-to-back requests");
        for (int i = 0; i < 5; i++) begin
            ra[i]  = WIDTH'($urandom);
            rb[i]  = WIDTH'($urandom);
            rop[i] = 3'($urandom_range(0, 5));
        end
        res_ready   = 1'b1;
        idx         = 0;
        cyc         = 0;
        last_accept = -1;
        results     = 0;
        in_valid    = 1'b1;
        in_a        = ra[0];
        in_b        = rb[0];
        in_op       = rop[0];
        while (results < 5 && cyc < 5 * PERIOD + 50) begin
            if (res_valid) begin
                checkOutput("b2b pending", 32'(expq.size()), 32'd1);
                if (expq.size() > 0) begin
                    expv = expq.pop_front();
                    checkOutput("b2b res_data", 32'(res_data), 32'(expv[WIDTH-1:0]));
                    checkOutput("b2b res_carry", 32'(res_carry), 32'(expCarry(expv)));
                end
                results++;
            end
            accept = in_valid && in_ready;
            if (accept) begin
                if (last_accept >= 0) begin
                    checkOutput("b2b interval", 32'(cyc - last_accept), 32'(PERIOD));
                end
                last_accept = cyc;
                expq.push_back(refModel(in_op, in_a, in_b));
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (accept) begin
                idx++;
                if (idx < 5) begin
                    in_a  = ra[idx];
                    in_b  = rb[idx];
                    in_op = rop[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        checkOutput("b2b results", 32'(results), 32'd5);
        res_ready = 1'b0;
        in_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);

        $display("[TB] randomized operations");
        for (int i = 0; i < 8; i++) begin
            applyStimulus("random", 3'($urandom_range(0, 7)), WIDTH'($urandom), WIDTH'($urandom),
                          int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
